// File: rtl/fq_pkg.sv
// Shared definitions for the dual-issue fetch queue.
// Holds the default widths and the packed entry layout {pred, pc, instr}.
// The storage array keeps each entry in this bit order.
package fq_pkg;

  localparam int DEPTH_DEF   = 8;
  localparam int PC_W_DEF    = 11;
  localparam int INSTR_W_DEF = 32;
  localparam int ENTRY_W     = PC_W_DEF + INSTR_W_DEF + 1;

  // Prediction bit is the MSB and the instruction word is the LSBs.
  typedef struct packed {
    logic                   pred;
    logic [PC_W_DEF-1:0]    pc;
    logic [INSTR_W_DEF-1:0] instr;
  } fq_entry_t;

endpackage

// File: rtl/fq_storage.sv
// Register array for the fetch queue. It holds DEPTH x WIDTH entries.
// Ports:
//   clk                    - clock, rising edge
//   we0/waddr0/wdata0      - write port 0 (older of a fetched pair)
//   we1/waddr1/wdata1      - write port 1 (younger of a fetched pair)
//   raddr0/rdata0          - asynchronous read port 0 (queue head)
//   raddr1/rdata1          - asynchronous read port 1 (head + 1)
// The array has no reset. The control logic never presents an unwritten
// slot as valid, so the array contents do not need clearing.
module fq_storage
  import fq_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int WIDTH = ENTRY_W
) (
  input  logic                     clk,
  input  logic                     we0,
  input  logic [$clog2(DEPTH)-1:0] waddr0,
  input  logic [WIDTH-1:0]         wdata0,
  input  logic                     we1,
  input  logic [$clog2(DEPTH)-1:0] waddr1,
  input  logic [WIDTH-1:0]         wdata1,
  input  logic [$clog2(DEPTH)-1:0] raddr0,
  output logic [WIDTH-1:0]         rdata0,
  input  logic [$clog2(DEPTH)-1:0] raddr1,
  output logic [WIDTH-1:0]         rdata1
);

  logic [WIDTH-1:0] mem [DEPTH];

  // The two write addresses are always tail and tail+1. DEPTH >= 4, so the
  // two addresses never collide.
  always_ff @(posedge clk) begin
    if (we0) mem[waddr0] <= wdata0;
    if (we1) mem[waddr1] <= wdata1;
  end

  assign rdata0 = mem[raddr0];
  assign rdata1 = mem[raddr1];

endmodule

// File: rtl/fetch_queue.sv
// Dual-issue instruction queue between fetch and the IF/ID register.
// Ports:
//   clk, rst               - clock and asynchronous active-high reset
//   enable                 - global run enable; low freezes all state
//   flush                  - redirect; empties the queue on the next edge
//   in_valid[1:0]          - fetched slot valids (2'b10 is treated as none)
//   in_pc*/in_instr*/in_pred* - fetched pair, slot0 older than slot1
//   in_ready               - room for two entries this cycle
//   out_valid[1:0]         - head / head+1 valid
//   out_pc*/out_instr*/out_pred* - head and head+1 entries (zero if invalid)
//   out_pop[1:0]           - entries decode consumes this cycle
//   count                  - current occupancy
module fetch_queue
  import fq_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEF,
  parameter int PC_W    = PC_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic                       flush,
  input  logic [1:0]                 in_valid,
  input  logic [PC_W-1:0]            in_pc0,
  input  logic [PC_W-1:0]            in_pc1,
  input  logic [INSTR_W-1:0]         in_instr0,
  input  logic [INSTR_W-1:0]         in_instr1,
  input  logic                       in_pred0,
  input  logic                       in_pred1,
  output logic                       in_ready,
  output logic [1:0]                 out_valid,
  output logic [PC_W-1:0]            out_pc0,
  output logic [PC_W-1:0]            out_pc1,
  output logic [INSTR_W-1:0]         out_instr0,
  output logic [INSTR_W-1:0]         out_instr1,
  output logic                       out_pred0,
  output logic                       out_pred1,
  input  logic [1:0]                 out_pop,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = PC_W + INSTR_W + 1;

  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [1:0]    push_n;
  logic [1:0]    push_amt;
  logic [1:0]    pop_req;
  logic [1:0]    pop_n;
  logic          push_go;
  logic [EW-1:0] wdata0;
  logic [EW-1:0] wdata1;
  logic [EW-1:0] rdata0;
  logic [EW-1:0] rdata1;

  // Ready uses only the registered count. A same-cycle pop cannot create
  // room, which keeps the decode -> fetch path free of combinational loops.
  assign in_ready = (count <= CW'(DEPTH - 2));

  always_comb begin
    push_n = 2'd0;
    if (in_valid == 2'b11)      push_n = 2'd2;
    else if (in_valid == 2'b01) push_n = 2'd1;
  end

  assign push_go  = in_ready && enable && !flush;
  assign push_amt = push_go ? push_n : 2'd0;

  // Decode cannot consume more than two entries or more than are present.
  assign pop_req = (out_pop > 2'd2) ? 2'd2 : out_pop;
  assign pop_n   = (CW'(pop_req) > count) ? count[1:0] : pop_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (enable) begin
      if (flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        head  <= head + AW'(pop_n);
        tail  <= tail + AW'(push_amt);
        count <= count + CW'(push_amt) - CW'(pop_n);
      end
    end
  end

  assign wdata0 = {in_pred0, in_pc0, in_instr0};
  assign wdata1 = {in_pred1, in_pc1, in_instr1};

  fq_storage #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_storage (
    .clk    (clk),
    .we0    (push_go && (push_n != 2'd0)),
    .waddr0 (tail),
    .wdata0 (wdata0),
    .we1    (push_go && (push_n == 2'd2)),
    .waddr1 (tail + AW'(1)),
    .wdata1 (wdata1),
    .raddr0 (head),
    .rdata0 (rdata0),
    .raddr1 (head + AW'(1)),
    .rdata1 (rdata1)
  );

  assign out_valid[0] = (count >= CW'(1));
  assign out_valid[1] = (count >= CW'(2));

  // Invalid slots read as zero, so stale array contents never reach decode.
  assign out_pred0  = out_valid[0] ? rdata0[EW-1]           : 1'b0;
  assign out_pc0    = out_valid[0] ? rdata0[INSTR_W +: PC_W] : '0;
  assign out_instr0 = out_valid[0] ? rdata0[INSTR_W-1:0]    : '0;
  assign out_pred1  = out_valid[1] ? rdata1[EW-1]           : 1'b0;
  assign out_pc1    = out_valid[1] ? rdata1[INSTR_W +: PC_W] : '0;
  assign out_instr1 = out_valid[1] ? rdata1[INSTR_W-1:0]    : '0;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue. A queue of expected entries is
// updated whenever stimulus is applied. The head entries are compared
// with the DUT outputs as decode pops them.
module tb_fetch_queue;

  localparam int DEPTH   = 8;
  localparam int PC_W    = 11;
  localparam int INSTR_W = 32;
  localparam int CW      = $clog2(DEPTH) + 1;

  typedef struct {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
    logic               pred;
  } ent_t;

  logic               clk = 1'b0;
  logic               rst;
  logic               enable;
  logic               flush;
  logic [1:0]         in_valid;
  logic [PC_W-1:0]    in_pc0, in_pc1;
  logic [INSTR_W-1:0] in_instr0, in_instr1;
  logic               in_pred0, in_pred1;
  logic               in_ready;
  logic [1:0]         out_valid;
  logic [PC_W-1:0]    out_pc0, out_pc1;
  logic [INSTR_W-1:0] out_instr0, out_instr1;
  logic               out_pred0, out_pred1;
  logic [1:0]         out_pop;
  logic [CW-1:0]      count;

  ent_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  fetch_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
    .clk(clk), .rst(rst), .enable(enable), .flush(flush),
    .in_valid(in_valid), .in_pc0(in_pc0), .in_pc1(in_pc1),
    .in_instr0(in_instr0), .in_instr1(in_instr1),
    .in_pred0(in_pred0), .in_pred1(in_pred1), .in_ready(in_ready),
    .out_valid(out_valid), .out_pc0(out_pc0), .out_pc1(out_pc1),
    .out_instr0(out_instr0), .out_instr1(out_instr1),
    .out_pred0(out_pred0), .out_pred1(out_pred1),
    .out_pop(out_pop), .count(count)
  );

  always #5 clk = ~clk;

  // Applies inputs for one clock, updates the reference queue, and returns
  // in the low clock phase with inputs idle.
  task automatic cycle(input logic [1:0] v,
                       input logic [PC_W-1:0] pa, input logic [INSTR_W-1:0] ia, input logic ra,
                       input logic [PC_W-1:0] pb, input logic [INSTR_W-1:0] ib, input logic rb,
                       input logic [1:0] pop, input logic en, input logic fl);
    ent_t ea, eb;
    bit   acc;
    int   n;
    ea.pc = pa; ea.instr = ia; ea.pred = ra;
    eb.pc = pb; eb.instr = ib; eb.pred = rb;
    in_valid = v; in_pc0 = pa; in_instr0 = ia; in_pred0 = ra;
    in_pc1 = pb; in_instr1 = ib; in_pred1 = rb;
    out_pop = pop; enable = en; flush = fl;
    acc = (DEPTH - sb.size()) >= 2;
    n   = (int'(pop) > sb.size()) ? sb.size() : int'(pop);
    @(posedge clk);
    if (en) begin
      if (fl) sb.delete();
      else begin
        for (int k = 0; k < n; k++) void'(sb.pop_front());
        if (acc && v == 2'b01) sb.push_back(ea);
        if (acc && v == 2'b11) begin sb.push_back(ea); sb.push_back(eb); end
      end
    end
    @(negedge clk);
    in_valid = 2'b00; out_pop = 2'd0; flush = 1'b0; enable = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (count !== '0) begin n_fail++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_ready: got %b expected 1", in_ready); end
    n_checks++; if (out_valid !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_valid: got %b expected 00", out_valid); end
    n_checks++; if (out_instr0 !== '0) begin n_fail++; $display("[TB] FAIL reset_instr0: got %h expected 0", out_instr0); end
    // Pop at empty and the illegal 2'b10 push must both do nothing.
    cycle(2'b10, 11'd9, 32'h1234, 1'b1, 11'd9, 32'h1234, 1'b1, 2'd2, 1'b1, 1'b0);
    n_checks++; if (count !== '0) begin n_fail++; $display("[TB] FAIL empty_pop_count: got %0d expected 0", count); end
    n_checks++; if (out_valid !== 2'b00) begin n_fail++; $display("[TB] FAIL empty_pop_valid: got %b expected 00", out_valid); end
  endtask

  task automatic test_push_pair();
    cycle(2'b11, 11'd5, 32'h8C220004, 1'b0, 11'd6, 32'h00431020, 1'b1, 2'd0, 1'b1, 1'b0);
    n_checks++; if (out_valid !== 2'b11) begin n_fail++; $display("[TB] FAIL pair_valid: got %b expected 11", out_valid); end
    n_checks++; if (out_pc0 !== 11'd5) begin n_fail++; $display("[TB] FAIL pair_pc0: got %0d expected 5", out_pc0); end
    n_checks++; if (out_pc1 !== 11'd6) begin n_fail++; $display("[TB] FAIL pair_pc1: got %0d expected 6", out_pc1); end
    n_checks++; if (out_pred1 !== 1'b1) begin n_fail++; $display("[TB] FAIL pair_pred1: got %b expected 1", out_pred1); end
    n_checks++; if (count !== CW'(2)) begin n_fail++; $display("[TB] FAIL pair_count: got %0d expected 2", count); end
    // Pop both, checking each scoreboard entry against the head slots.
    n_checks++; if (out_instr0 !== sb[0].instr || out_pred0 !== sb[0].pred) begin n_fail++; $display("[TB] FAIL pair_head0: got %h/%b expected %h/%b", out_instr0, out_pred0, sb[0].instr, sb[0].pred); end
    n_checks++; if (out_instr1 !== sb[1].instr) begin n_fail++; $display("[TB] FAIL pair_head1: got %h expected %h", out_instr1, sb[1].instr); end
    cycle(2'b00, 11'd0, 32'd0, 1'b0, 11'd0, 32'd0, 1'b0, 2'd2, 1'b1, 1'b0);
    n_checks++; if (out_valid !== 2'b00 || count !== '0) begin n_fail++; $display("[TB] FAIL pair_drain: got %b/%0d expected 00/0", out_valid, count); end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < DEPTH - 1; i++)
      cycle(2'b01, 11'(100 + i), $urandom, 1'($urandom_range(0, 1)), 11'd0, 32'd0, 1'b0, 2'd0, 1'b1, 1'b0);
    n_checks++; if (count !== CW'(DEPTH - 1)) begin n_fail++; $display("[TB] FAIL fill_count: got %0d expected %0d", count, DEPTH - 1); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL fill_ready: got %b expected 0", in_ready); end
    cycle(2'b11, 11'd200, $urandom, 1'b0, 11'd201, $urandom, 1'b0, 2'd0, 1'b1, 1'b0);
    n_checks++; if (count !== CW'(DEPTH - 1)) begin n_fail++; $display("[TB] FAIL full_refuse: got %0d expected %0d", count, DEPTH - 1); end
    n_checks++; if (out_pc0 !== sb[0].pc || out_pc0 !== 11'd100) begin n_fail++; $display("[TB] FAIL full_head: got %0d expected %0d", out_pc0, sb[0].pc); end
    cycle(2'b00, 11'd0, 32'd0, 1'b0, 11'd0, 32'd0, 1'b0, 2'd1, 1'b1, 1'b0);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL pop1_ready: got %b expected 1", in_ready); end
    while (sb.size() > 0) begin
      n_checks++; if (out_pc0 !== sb[0].pc || out_instr0 !== sb[0].instr || out_pred0 !== sb[0].pred) begin n_fail++; $display("[TB] FAIL fill_drain0: got pc %0d expected %0d", out_pc0, sb[0].pc); end
      if (sb.size() > 1) begin
        n_checks++; if (out_pc1 !== sb[1].pc || out_instr1 !== sb[1].instr) begin n_fail++; $display("[TB] FAIL fill_drain1: got pc %0d expected %0d", out_pc1, sb[1].pc); end
      end
      cycle(2'b00, 11'd0, 32'd0, 1'b0, 11'd0, 32'd0, 1'b0, 2'd2, 1'b1, 1'b0);
    end
    n_checks++; if (count !== '0) begin n_fail++; $display("[TB] FAIL fill_empty: got %0d expected 0", count); end
  endtask

  task automatic test_wrap();
    do_reset();
    // Walk head and tail to slot DEPTH-1 with one entry in flight.
    for (int i = 0; i < DEPTH - 1; i++)
      cycle(2'b01, 11'(i), $urandom, 1'b0, 11'd0, 32'd0, 1'b0, 2'd1, 1'b1, 1'b0);
    cycle(2'b00, 11'd0, 32'd0, 1'b0, 11'd0, 32'd0, 1'b0, 2'd1, 1'b1, 1'b0);
    n_checks++; if (count !== '0) begin n_fail++; $display("[TB] FAIL wrap_prep: got %0d expected 0", count); end
    cycle(2'b11, 11'd20, $urandom, 1'b1, 11'd21, $urandom, 1'b0, 2'd0, 1'b1, 1'b0);
    n_checks++; if (out_pc0 !== 11'd20 || out_instr0 !== sb[0].instr || out_pred0 !== 1'b1) begin n_fail++; $display("[TB] FAIL wrap_head0: got pc %0d expected 20", out_pc0); end
    n_checks++; if (out_pc1 !== 11'd21 || out_instr1 !== sb[1].instr || out_pred1 !== 1'b0) begin n_fail++; $display("[TB] FAIL wrap_head1: got pc %0d expected 21", out_pc1); end
    cycle(2'b00, 11'd0, 32'd0, 1'b0, 11'd0, 32'd0, 1'b0, 2'd2, 1'b1, 1'b0);
    n_checks++; if (count !== '0 || out_valid !== 2'b00) begin n_fail++; $display("[TB] FAIL wrap_drain: got %0d/%b expected 0/00", count, out_valid); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    cycle(2'b11, 11'd40, $urandom, 1'b0, 11'd41, $urandom, 1'b1, 2'd0, 1'b1, 1'b0);
    n_checks++; if (out_pc0 !== sb[0].pc || out_pc1 !== sb[1].pc) begin n_fail++; $display("[TB] FAIL b2b_first: got %0d,%0d expected %0d,%0d", out_pc0, out_pc1, sb[0].pc, sb[1].pc); end
    cycle(2'b11, 11'd42, $urandom, 1'b1, 11'd43, $urandom, 1'b0, 2'd2, 1'b1, 1'b0);
    n_checks++; if (count !== CW'(2)) begin n_fail++; $display("[TB] FAIL b2b_count: got %0d expected 2", count); end
    n_checks++; if (out_pc0 !== 11'd42 || out_instr0 !== sb[0].instr || out_pred0 !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_new_head: got pc %0d expected 42", out_pc0); end
    cycle(2'b00, 11'd0, 32'd0, 1'b0, 11'd0, 32'd0, 1'b0, 2'd1, 1'b1, 1'b0);
    n_checks++; if (out_pc0 !== 11'd43 || out_valid !== 2'b01) begin n_fail++; $display("[TB] FAIL b2b_pop1: got pc %0d valid %b expected 43/01", out_pc0, out_valid); end
    // Over-pop: two requested with one present.
    cycle(2'b00, 11'd0, 32'd0, 1'b0, 11'd0, 32'd0, 1'b0, 2'd2, 1'b1, 1'b0);
    n_checks++; if (count !== '0) begin n_fail++; $display("[TB] FAIL overpop: got %0d expected 0", count); end
  endtask

  task automatic test_flush();
    do_reset();
    cycle(2'b11, 11'd30, $urandom, 1'b0, 11'd31, $urandom, 1'b0, 2'd0, 1'b1, 1'b0);
    cycle(2'b11, 11'd32, $urandom, 1'b0, 11'd33, $urandom, 1'b0, 2'd0, 1'b1, 1'b0);
    cycle(2'b01, 11'd34, $urandom, 1'b0, 11'd0, 32'd0, 1'b0, 2'd0, 1'b1, 1'b0);
    n_checks++; if (count !== CW'(5)) begin n_fail++; $display("[TB] FAIL flush_prep: got %0d expected 5", count); end
    cycle(2'b11, 11'd44, $urandom, 1'b1, 11'd45, $urandom, 1'b1, 2'd1, 1'b1, 1'b1);
    n_checks++; if (count !== '0 || out_valid !== 2'b00) begin n_fail++; $display("[TB] FAIL flush_clear: got %0d/%b expected 0/00", count, out_valid); end
    n_checks++; if (out_pc0 !== '0) begin n_fail++; $display("[TB] FAIL flush_data: got %0d expected 0", out_pc0); end
    cycle(2'b11, 11'd50, $urandom, 1'b0, 11'd51, $urandom, 1'b1, 2'd0, 1'b1, 1'b0);
    cycle(2'b11, 11'd60, $urandom, 1'b0, 11'd61, $urandom, 1'b0, 2'd2, 1'b0, 1'b1);
    n_checks++; if (count !== CW'(2)) begin n_fail++; $display("[TB] FAIL frozen_count: got %0d expected 2", count); end
    n_checks++; if (out_pc0 !== 11'd50 || out_pc1 !== sb[1].pc || out_pred1 !== sb[1].pred) begin n_fail++; $display("[TB] FAIL frozen_head: got %0d,%0d expected 50,%0d", out_pc0, out_pc1, sb[1].pc); end
  endtask

  task automatic test_async_reset();
    cycle(2'b11, 11'd70, $urandom, 1'b1, 11'd71, $urandom, 1'b1, 2'd0, 1'b1, 1'b0);
    n_checks++; if (count !== CW'(sb.size())) begin n_fail++; $display("[TB] FAIL pre_reset_count: got %0d expected %0d", count, sb.size()); end
    #1 rst = 1'b1;
    #1;
    n_checks++; if (out_valid !== 2'b00 || count !== '0 || out_pc0 !== '0 || in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL async_reset: got %b/%0d/%0d expected 00/0/0", out_valid, count, out_pc0); end
    rst = 1'b0;
    sb.delete();
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; flush = 1'b0; in_valid = 2'b00; out_pop = 2'd0;
    in_pc0 = '0; in_pc1 = '0; in_instr0 = '0; in_instr1 = '0; in_pred0 = 1'b0; in_pred1 = 1'b0;
    @(negedge clk);
    test_reset();
    test_push_pair();
    test_fill();
    test_wrap();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
